// File: rtl/gpioemu_seq.sv
// Bus sequencer that drives a memory-mapped multiply emulator: write operands, start, poll, read results.
// Optional poll timeout enabled by defining GPIOEMU_SEQ_TIMEOUT_EN.
module gpioemu_seq #(
  parameter int POLL_LIMIT = 255,
  parameter int POLL_GAP   = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_a1,
  input  logic [23:0] in_a2,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [5:0]  res_l,
  output logic        res_ovf,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, WA1, WA2, START, POLL, GAP, RDW, RDL, OUT
  } state_t;

  localparam logic [15:0] ADDR_A1   = 16'h0380;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_RESW = 16'h0390;
  localparam logic [15:0] ADDR_RESL = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  // step holds the bus phase (SETUP/STROBE/SAMPLE) or the gap count.
  localparam int SW = (POLL_GAP > 4) ? $clog2(POLL_GAP) : 2;
  localparam logic [SW-1:0] STEP_STROBE = SW'(1);
  localparam logic [SW-1:0] STEP_SAMPLE = SW'(2);
  localparam logic [SW-1:0] STEP_GAP_END = SW'(POLL_GAP - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] step;
  logic          step_last;
  logic [23:0]   a1_r, a2_r;
  logic          accept;
  logic          poll_done;
  logic          timeout;

  assign in_ready  = n_reset && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign res_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign poll_done = (state == POLL) && step_last;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= (step_last || (state_nxt != state)) ? '0 : step + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    step_last = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = WA1;
      WA1: begin
        step_last = (step == STEP_STROBE);
        if (step_last) state_nxt = WA2;
      end
      WA2: begin
        step_last = (step == STEP_STROBE);
        if (step_last) state_nxt = START;
      end
      START: begin
        step_last = (step == STEP_STROBE);
        if (step_last) state_nxt = POLL;
      end
      POLL: begin
        step_last = (step == STEP_SAMPLE);
        if (step_last) begin
          if (sdata_in[1])       state_nxt = RDW;
          else if (timeout)      state_nxt = OUT;
          else if (POLL_GAP == 0) state_nxt = POLL;
          else                   state_nxt = GAP;
        end
      end
      GAP: begin
        step_last = (step == STEP_GAP_END);
        if (step_last) state_nxt = POLL;
      end
      RDW: begin
        step_last = (step == STEP_SAMPLE);
        if (step_last) state_nxt = RDL;
      end
      RDL: begin
        step_last = (step == STEP_SAMPLE);
        if (step_last) state_nxt = OUT;
      end
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    saddress  = 16'h0;
    sdata_out = 32'h0;
    swr       = 1'b0;
    srd       = 1'b0;
    case (state)
      WA1: begin
        saddress  = ADDR_A1;
        sdata_out = {8'h0, a1_r};
        swr       = (step == STEP_STROBE);
      end
      WA2: begin
        saddress  = ADDR_A2;
        sdata_out = {8'h0, a2_r};
        swr       = (step == STEP_STROBE);
      end
      START: begin
        saddress = ADDR_CTRL;
        swr      = (step == STEP_STROBE);
      end
      POLL: begin
        saddress = ADDR_CTRL;
        srd      = (step == STEP_STROBE);
      end
      RDW: begin
        saddress = ADDR_RESW;
        srd      = (step == STEP_STROBE);
      end
      RDL: begin
        saddress = ADDR_RESL;
        srd      = (step == STEP_STROBE);
      end
      default: ;
    endcase
  end

  // NOTE: operand registers carry no reset; they are always loaded on accept before any use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a1_r <= in_a1;
      a2_r <= in_a2;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      res_w   <= 32'h0;
      res_l   <= 6'h0;
      res_ovf <= 1'b0;
    end else if (accept) begin
      res_w   <= 32'h0;
      res_l   <= 6'h0;
      res_ovf <= 1'b0;
    end else begin
      if (poll_done && sdata_in[1]) res_ovf <= ~sdata_in[0];
      if ((state == RDW) && step_last) res_w <= sdata_in;
      if ((state == RDL) && step_last) res_l <= sdata_in[5:0];
    end
  end

`ifdef GPIOEMU_SEQ_TIMEOUT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_cnt;

  // poll_cnt holds the number of failed polls so far; the last allowed failure times out.
  assign timeout = (poll_cnt >= PW'(POLL_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      poll_cnt <= '0;
      res_err  <= 1'b0;
    end else if (accept) begin
      poll_cnt <= '0;
      res_err  <= 1'b0;
    end else if (poll_done && !sdata_in[1]) begin
      if (poll_cnt != PW'(POLL_LIMIT)) poll_cnt <= poll_cnt + 1'b1;
      if (timeout) res_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpioemu_seq.sv
// Directed self-checking bench for gpioemu_seq with a simple register-map model of the emulator.
// Timeout expectations follow whether GPIOEMU_SEQ_TIMEOUT_EN is defined.
module tb_gpioemu_seq;

  localparam int POLL_LIMIT = 4;
  localparam int POLL_GAP   = 2;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a1, in_a2;
  logic [15:0] saddress;
  logic        swr, srd;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_w;
  logic [5:0]  res_l;
  logic        res_ovf, res_err, busy;

  gpioemu_seq #(.POLL_LIMIT(POLL_LIMIT), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .n_reset(n_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a1(in_a1), .in_a2(in_a2),
    .saddress(saddress), .swr(swr), .srd(srd), .sdata_out(sdata_out), .sdata_in(sdata_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_w(res_w), .res_l(res_l),
    .res_ovf(res_ovf), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat;

  // emulator model: status depends on how many polls have been seen
  int          polls_seen = 0;
  int          n_busy = 0;
  logic [1:0]  st_busy = 2'b01;
  logic [1:0]  st_ready = 2'b11;
  logic [31:0] rd_w = 32'h0;
  logic [31:0] rd_raw_l = 32'h0;
  logic        bad_strobe = 1'b0;
  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          poll_cyc[$];

  always_comb begin
    case (saddress)
      16'h03A0: sdata_in = {30'h0, (polls_seen <= n_busy) ? st_busy : st_ready};
      16'h0390: sdata_in = rd_w;
      16'h0398: sdata_in = rd_raw_l;
      default:  sdata_in = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (swr && srd) bad_strobe = 1'b1;
    if (swr) begin
      wr_addr.push_back(saddress);
      wr_data.push_back(sdata_out);
    end
    if (srd && saddress == 16'h03A0) begin
      polls_seen = polls_seen + 1;
      poll_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    poll_cyc.delete();
    polls_seen = 0;
  endtask

  task automatic start_op(input logic [23:0] a, input logic [23:0] b);
    clear_log();
    @(negedge clk);
    in_a1 = a;
    in_a2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    while (!res_valid && (cyc - acc_cyc) < 300) begin
      @(posedge clk);
      #1;
    end
    l = cyc - acc_cyc;
  endtask

  task automatic finish_op();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("back_to_idle_busy", busy, 1'b0);
    check("back_to_idle_valid", res_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset = 1'b0;
    in_valid = 1'b0;
    in_a1 = 24'h0;
    in_a2 = 24'h0;
    res_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_swr", swr, 1'b0);
    check("rst_srd", srd, 1'b0);
    check("rst_saddress", saddress, 16'h0);
    check("rst_sdata_out", sdata_out, 32'h0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_w", res_w, 32'h0);
    check("rst_res_l", res_l, 6'h0);
    check("rst_res_ovf", res_ovf, 1'b0);
    check("rst_res_err", res_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1'b1);

    // 3 x 5, ready on first poll; in_valid while busy and early res_ready are ignored
    n_busy = 0; st_ready = 2'b11; rd_w = 32'd15; rd_raw_l = 32'h0000_0004;
    start_op(24'd3, 24'd5);
    check("t1_busy", busy, 1'b1);
    check("t1_in_ready_busy", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_a1 = 24'h77; in_a2 = 24'h99; res_ready = 1'b1;
    @(negedge clk);
    check("t1_in_ready_held", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0; res_ready = 1'b0;
    wait_valid(lat);
    check("t1_latency", lat, 32'd15);
    check("t1_res_valid", res_valid, 1'b1);
    check("t1_res_w", res_w, 32'd15);
    check("t1_res_l", res_l, 6'd4);
    check("t1_res_ovf", res_ovf, 1'b0);
    check("t1_res_err", res_err, 1'b0);
    check("t1_nwrites", wr_addr.size(), 32'd3);
    check("t1_waddr0", wr_addr[0], 16'h0380);
    check("t1_waddr1", wr_addr[1], 16'h0388);
    check("t1_waddr2", wr_addr[2], 16'h03A0);
    check("t1_wdata0", wr_data[0], 32'd3);
    check("t1_wdata1", wr_data[1], 32'd5);
    check("t1_wdata2", wr_data[2], 32'd0);
    check("t1_polls", polls_seen, 32'd1);
    check("t1_out_saddress", saddress, 16'h0);
    check("t1_out_sdata_out", sdata_out, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("t1_hold_valid", res_valid, 1'b1);
    check("t1_hold_res_w", res_w, 32'd15);
    check("t1_hold_res_l", res_l, 6'd4);
    finish_op();

    // max operands, status 2'b10 -> overflow; only res_l low six bits are kept
    n_busy = 0; st_ready = 2'b10; rd_w = 32'hFE00_0001; rd_raw_l = 32'hABCD_EF08;
    start_op(24'hFF_FFFF, 24'hFF_FFFF);
    wait_valid(lat);
    check("t2_latency", lat, 32'd15);
    check("t2_wdata0", wr_data[0], 32'h00FF_FFFF);
    check("t2_wdata1", wr_data[1], 32'h00FF_FFFF);
    check("t2_res_w", res_w, 32'hFE00_0001);
    check("t2_res_l", res_l, 6'd8);
    check("t2_res_ovf", res_ovf, 1'b1);
    finish_op();

    // three busy polls then ready
    n_busy = 3; st_busy = 2'b01; st_ready = 2'b11; rd_w = 32'h1234_5678; rd_raw_l = 32'h0000_003F;
    start_op(24'd100, 24'd200);
    wait_valid(lat);
    check("t3_latency", lat, 32'd30);
    check("t3_polls", polls_seen, 32'd4);
    check("t3_poll_gap_first", poll_cyc[1] - poll_cyc[0], 32'd5);
    check("t3_poll_gap_last", poll_cyc[3] - poll_cyc[2], 32'd5);
    check("t3_res_w", res_w, 32'h1234_5678);
    check("t3_res_l", res_l, 6'h3F);
    check("t3_res_ovf", res_ovf, 1'b0);
    check("t3_res_err", res_err, 1'b0);
    finish_op();

    // status never ready
    n_busy = 1000; st_busy = 2'b00; rd_w = 32'hCAFE_F00D; rd_raw_l = 32'h0000_0015;
    start_op(24'd7, 24'd9);
`ifdef GPIOEMU_SEQ_TIMEOUT_EN
    wait_valid(lat);
    check("t4_latency", lat, 32'd24);
    check("t4_polls", polls_seen, 32'd4);
    check("t4_res_err", res_err, 1'b1);
    check("t4_res_w", res_w, 32'h0);
    check("t4_res_l", res_l, 6'h0);
    check("t4_res_ovf", res_ovf, 1'b0);
`else
    repeat (60) @(posedge clk);
    #1;
    check("t4_still_polling", res_valid, 1'b0);
    check("t4_polls_past_limit", polls_seen > 4, 1'b1);
    st_busy = 2'b11;
    wait_valid(lat);
    check("t4_res_valid", res_valid, 1'b1);
    check("t4_res_err", res_err, 1'b0);
    check("t4_res_w", res_w, 32'hCAFE_F00D);
    check("t4_res_l", res_l, 6'h15);
`endif
    finish_op();

    // reset during WA2 strobe
    n_busy = 0; st_ready = 2'b11; rd_w = 32'h0000_0002; rd_raw_l = 32'h1;
    start_op(24'd1, 24'd2);
    repeat (3) @(posedge clk);
    #1;
    check("t5_wa2_strobe_swr", swr, 1'b1);
    check("t5_wa2_strobe_addr", saddress, 16'h0388);
    n_reset = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_swr", swr, 1'b0);
    check("t5_rst_saddress", saddress, 16'h0);
    check("t5_rst_in_ready_low", in_ready, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_res_valid", res_valid, 1'b0);
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    check("t5_rel_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check("t5_idle_busy", busy, 1'b0);

    check("no_dual_strobe", bad_strobe, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
